// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-query and commit signals of the reorder buffer.
// The slave modport is the ROB side; the master modport is the core around it.
interface rob_if #(
    parameter int TAG_W  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) ();
    logic              issue_valid;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_is_branch;
    logic              issue_pred_taken;
    logic [DATA_W-1:0] issue_alt_pc;
    logic [TAG_W-1:0]  issue_tag;
    logic              rob_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_taken;
    logic [TAG_W-1:0]  query_tag1;
    logic [TAG_W-1:0]  query_tag2;
    logic              query_ready1;
    logic              query_ready2;
    logic [DATA_W-1:0] query_value1;
    logic [DATA_W-1:0] query_value2;
    logic              commit_valid;
    logic [REG_W-1:0]  commit_index;
    logic [DATA_W-1:0] commit_value;
    logic [TAG_W-1:0]  commit_tag;
    logic              jump_wrong;
    logic [DATA_W-1:0] redirect_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
        output cdb_valid, cdb_tag, cdb_value, cdb_taken, query_tag1, query_tag2,
        input  issue_tag, rob_full, query_ready1, query_ready2, query_value1, query_value2,
        input  commit_valid, commit_index, commit_value, commit_tag, jump_wrong, redirect_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
        input  cdb_valid, cdb_tag, cdb_value, cdb_taken, query_tag1, query_tag2,
        output issue_tag, rob_full, query_ready1, query_ready2, query_value1, query_value2,
        output commit_valid, commit_index, commit_value, commit_tag, jump_wrong, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: captures CDB results, retires one entry per cycle
// in program order, and flushes with a redirect on a mispredicted head branch.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    rob_if.slave bus
);
    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_has_dest;
    logic [ROB_SIZE-1:0] r_is_branch;
    logic [ROB_SIZE-1:0] r_pred_taken;
    logic [ROB_SIZE-1:0] r_taken;
    logic [REG_W-1:0]    r_rd     [ROB_SIZE];
    logic [DATA_W-1:0]   r_value  [ROB_SIZE];
    logic [DATA_W-1:0]   r_alt_pc [ROB_SIZE];
    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;

    logic                r_commit_valid;
    logic [REG_W-1:0]    r_commit_index;
    logic [DATA_W-1:0]   r_commit_value;
    logic [TAG_W-1:0]    r_commit_tag;
    logic                r_jump_wrong;
    logic [DATA_W-1:0]   r_redirect_pc;

    logic w_full;
    logic w_issue_ok;
    logic w_head_ready;
    logic w_mispredict;
    logic w_pop;
    logic w_q1_busy;
    logic w_q2_busy;
    logic w_q1_byp;
    logic w_q2_byp;

    // Retirement decisions look only at registered state, so a CDB hit on the head retires next cycle.
    assign w_full       = (r_count == (TAG_W+1)'(ROB_SIZE));
    assign w_issue_ok   = bus.issue_valid && !w_full && !r_jump_wrong;
    assign w_head_ready = (r_count != '0) && r_ready[r_head];
    assign w_mispredict = w_head_ready && r_is_branch[r_head] &&
                          (r_taken[r_head] != r_pred_taken[r_head]);
    assign w_pop        = w_head_ready && !w_mispredict;

    assign w_q1_busy = r_busy[bus.query_tag1];
    assign w_q2_busy = r_busy[bus.query_tag2];
    assign w_q1_byp  = w_q1_busy && bus.cdb_valid && (bus.cdb_tag == bus.query_tag1);
    assign w_q2_byp  = w_q2_busy && bus.cdb_valid && (bus.cdb_tag == bus.query_tag2);

    assign bus.issue_tag    = r_tail;
    assign bus.rob_full     = w_full;
    assign bus.query_ready1 = w_q1_busy && (r_ready[bus.query_tag1] || w_q1_byp);
    assign bus.query_ready2 = w_q2_busy && (r_ready[bus.query_tag2] || w_q2_byp);
    assign bus.query_value1 = !w_q1_busy ? '0 : (w_q1_byp ? bus.cdb_value : r_value[bus.query_tag1]);
    assign bus.query_value2 = !w_q2_busy ? '0 : (w_q2_byp ? bus.cdb_value : r_value[bus.query_tag2]);

    assign bus.commit_valid = r_commit_valid;
    assign bus.commit_index = r_commit_index;
    assign bus.commit_value = r_commit_value;
    assign bus.commit_tag   = r_commit_tag;
    assign bus.jump_wrong   = r_jump_wrong;
    assign bus.redirect_pc  = r_redirect_pc;

    // Buffer state and commit/flush outputs; rdy=0 freezes everything including the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= '0;
            r_ready        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_index <= '0;
            r_commit_value <= '0;
            r_commit_tag   <= '0;
            r_jump_wrong   <= 1'b0;
            r_redirect_pc  <= '0;
        end else if (rdy) begin
            r_commit_valid <= 1'b0;
            r_jump_wrong   <= 1'b0;
            if (w_mispredict) begin
                // Same-cycle issue and CDB writes die with the flush.
                r_jump_wrong  <= 1'b1;
                r_redirect_pc <= r_alt_pc[r_head];
                r_busy        <= '0;
                r_ready       <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
            end else begin
                if (w_issue_ok) begin
                    r_busy[r_tail]       <= 1'b1;
                    r_ready[r_tail]      <= 1'b0;
                    r_has_dest[r_tail]   <= !bus.issue_is_branch && (bus.issue_rd != '0);
                    r_is_branch[r_tail]  <= bus.issue_is_branch;
                    r_pred_taken[r_tail] <= bus.issue_pred_taken;
                    r_rd[r_tail]         <= bus.issue_rd;
                    r_alt_pc[r_tail]     <= bus.issue_alt_pc;
                    r_tail               <= r_tail + TAG_W'(1);
                end
                if (bus.cdb_valid && r_busy[bus.cdb_tag]) begin
                    r_ready[bus.cdb_tag] <= 1'b1;
                    r_value[bus.cdb_tag] <= bus.cdb_value;
                    r_taken[bus.cdb_tag] <= bus.cdb_taken;
                end
                if (w_pop) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + TAG_W'(1);
                    if (!r_is_branch[r_head]) begin
                        r_commit_valid <= r_has_dest[r_head];
                        r_commit_index <= r_rd[r_head];
                        r_commit_value <= r_value[r_head];
                        r_commit_tag   <= r_head;
                    end
                end
                r_count <= r_count + (TAG_W+1)'(w_issue_ok) - (TAG_W+1)'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: program-order queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   model_on = 1'b0;

    always #5 clk = ~clk;

    rob_if #(.TAG_W(4), .REG_W(5), .DATA_W(32)) bus ();

    reorder_buffer #(.ROB_SIZE(16), .TAG_W(4), .REG_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          br;
        bit          pred;
        bit          done;
        bit          taken;
        logic [31:0] val;
        logic [31:0] alt;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_tail;
    bit          e_cv, e_jw;
    logic [4:0]  e_ci;
    logic [31:0] e_cval, e_rpc;
    logic [3:0]  e_ctag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Program-order model: the queue front is the oldest in-flight instruction.
    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            q.delete();
            m_tail = 4'd0;
            e_cv = 1'b0; e_jw = 1'b0; e_ci = 5'd0; e_cval = 32'd0; e_ctag = 4'd0; e_rpc = 32'd0;
        end else if (rdy && model_on) begin
            bit was_full, was_jw, head_done, new_cv;
            was_full  = (q.size() == 16);
            was_jw    = e_jw;
            head_done = (q.size() > 0) && q[0].done;
            new_cv    = 1'b0;
            if (head_done && q[0].br && (q[0].taken != q[0].pred)) begin
                e_rpc = q[0].alt;
                q.delete();
                m_tail = 4'd0;
                e_jw = 1'b1;
            end else begin
                e_jw = 1'b0;
                if (head_done) begin
                    if (!q[0].br) begin
                        new_cv = (q[0].rd != 5'd0);
                        e_ci = q[0].rd; e_cval = q[0].val; e_ctag = q[0].tag;
                    end
                    void'(q.pop_front());
                end
                if (bus.cdb_valid) begin
                    foreach (q[i]) begin
                        if (q[i].tag == bus.cdb_tag) begin
                            q[i].done = 1'b1; q[i].val = bus.cdb_value; q[i].taken = bus.cdb_taken;
                        end
                    end
                end
                if (bus.issue_valid && !was_full && !was_jw) begin
                    ent_t e;
                    e.tag = m_tail; e.rd = bus.issue_rd; e.br = bus.issue_is_branch;
                    e.pred = bus.issue_pred_taken; e.alt = bus.issue_alt_pc;
                    e.done = 1'b0; e.taken = 1'b0; e.val = 32'd0;
                    q.push_back(e);
                    m_tail = m_tail + 4'd1;
                end
            end
            e_cv = new_cv;
        end
    end

    task automatic exp_query(input logic [3:0] t, output bit r, output bit busy, output logic [31:0] v);
        r = 1'b0; busy = 1'b0; v = 32'd0;
        foreach (q[i]) begin
            if (q[i].tag == t) begin
                busy = 1'b1;
                if (bus.cdb_valid && bus.cdb_tag == t) begin
                    r = 1'b1; v = bus.cdb_value;
                end else begin
                    r = q[i].done; v = q[i].val;
                end
            end
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (model_on) begin
            bit r, b;
            logic [31:0] v;
            chk("issue_tag", 32'(bus.issue_tag), 32'(m_tail));
            chk("rob_full", 32'(bus.rob_full), 32'(q.size() == 16));
            chk("count", 32'(dut.r_count), 32'(q.size()));
            chk("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
            if (e_cv) begin
                chk("commit_index", 32'(bus.commit_index), 32'(e_ci));
                chk("commit_value", bus.commit_value, e_cval);
                chk("commit_tag", 32'(bus.commit_tag), 32'(e_ctag));
            end
            chk("jump_wrong", 32'(bus.jump_wrong), 32'(e_jw));
            if (e_jw) chk("redirect_pc", bus.redirect_pc, e_rpc);
            exp_query(bus.query_tag1, r, b, v);
            chk("query_ready1", 32'(bus.query_ready1), 32'(r));
            if (r || !b) chk("query_value1", bus.query_value1, v);
            exp_query(bus.query_tag2, r, b, v);
            chk("query_ready2", 32'(bus.query_ready2), 32'(r));
            if (r || !b) chk("query_value2", bus.query_value2, v);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; bus.issue_is_branch = 1'b0;
        bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = 32'd0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = 4'd0; bus.cdb_value = 32'd0; bus.cdb_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1; rdy = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input bit br, input bit pred, input logic [31:0] alt);
        bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_is_branch = br;
        bus.issue_pred_taken = pred; bus.issue_alt_pc = alt;
        tick();
        bus.issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v, input bit tk);
        bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_value = v; bus.cdb_taken = tk;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    initial begin
        bus.query_tag1 = 4'd0; bus.query_tag2 = 4'd0;
        do_reset();
        chk("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
        chk("rst_issue_tag", 32'(bus.issue_tag), 32'd0);

        // Single instruction round trip.
        issue(5'd5, 1'b0, 1'b0, 32'd0);
        tick(); tick();
        cdb(4'd0, 32'h1234, 1'b0);
        tick();
        chk("t1_commit_valid", 32'(bus.commit_valid), 32'd1);
        chk("t1_commit_index", 32'(bus.commit_index), 32'd5);
        chk("t1_commit_value", bus.commit_value, 32'h1234);
        chk("t1_commit_tag", 32'(bus.commit_tag), 32'd0);
        chk("t1_count", 32'(dut.r_count), 32'd0);

        // Fill, overflow attempt, reverse-order completion, in-order retirement.
        do_reset();
        for (int i = 0; i < 16; i++) issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
        chk("t2_full", 32'(bus.rob_full), 32'd1);
        issue(5'd17, 1'b0, 1'b0, 32'd0);
        chk("t2_tail_wrap", 32'(bus.issue_tag), 32'd0);
        chk("t2_count_full", 32'(dut.r_count), 32'd16);
        for (int i = 15; i >= 0; i--) cdb(4'(i), 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t2_order_tag", 32'(bus.commit_tag), 32'(i));
            chk("t2_order_value", bus.commit_value, 32'h100 + 32'(i));
        end
        chk("t2_empty", 32'(dut.r_count), 32'd0);

        // rd=0 and a correctly predicted branch retire silently.
        issue(5'd0, 1'b0, 1'b0, 32'd0);
        issue(5'd3, 1'b1, 1'b1, 32'h40);
        cdb(4'd0, 32'h77, 1'b0);
        cdb(4'd1, 32'h0, 1'b1);
        tick(); tick();
        chk("t3_count", 32'(dut.r_count), 32'd0);
        chk("t3_jump_wrong", 32'(bus.jump_wrong), 32'd0);

        // Mispredicted branch at tag 2 with three younger entries.
        do_reset();
        issue(5'd1, 1'b0, 1'b0, 32'd0);
        issue(5'd2, 1'b0, 1'b0, 32'd0);
        issue(5'd0, 1'b1, 1'b0, 32'h100);
        for (int i = 3; i < 6; i++) issue(5'(i), 1'b0, 1'b0, 32'd0);
        cdb(4'd0, 32'hA0, 1'b0);
        cdb(4'd1, 32'hA1, 1'b0);
        for (int i = 3; i < 6; i++) cdb(4'(i), 32'hB0 + 32'(i), 1'b0);
        cdb(4'd2, 32'h0, 1'b1);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        tick();
        chk("t4_jump_wrong", 32'(bus.jump_wrong), 32'd1);
        chk("t4_redirect", bus.redirect_pc, 32'h100);
        chk("t4_count", 32'(dut.r_count), 32'd0);
        tick();
        chk("t4_jw_pulse", 32'(bus.jump_wrong), 32'd0);
        chk("t4_issue_dropped", 32'(dut.r_count), 32'd0);
        bus.issue_valid = 1'b0;

        // CDB bypass on the query port.
        do_reset();
        issue(5'd7, 1'b0, 1'b0, 32'd0);
        for (int i = 1; i < 4; i++) issue(5'(i), 1'b0, 1'b0, 32'd0);
        bus.query_tag1 = 4'd3;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd3; bus.cdb_value = 32'hAB;
        #1;
        chk("t5_q_ready", 32'(bus.query_ready1), 32'd1);
        chk("t5_q_value", bus.query_value1, 32'hAB);
        tick();
        bus.cdb_valid = 1'b0;

        // Stall with a ready head, then reset mid-stream.
        cdb(4'd0, 32'h55, 1'b0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_stall_cv", 32'(bus.commit_valid), 32'd0);
            chk("t6_stall_count", 32'(dut.r_count), 32'd4);
        end
        rdy = 1'b1;
        tick();
        chk("t6_commit_valid", 32'(bus.commit_valid), 32'd1);
        chk("t6_commit_value", bus.commit_value, 32'h55);
        chk("t6_commit_index", 32'(bus.commit_index), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_cv", 32'(bus.commit_valid), 32'd0);
        chk("t6_rst_value", bus.commit_value, 32'd0);
        chk("t6_rst_count", 32'(dut.r_count), 32'd0);
        chk("t6_rst_jw", 32'(bus.jump_wrong), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(999) < 4);
            rdy = ($urandom_range(99) < 90);
            bus.issue_valid      = ($urandom_range(99) < 55);
            bus.issue_rd         = 5'($urandom);
            bus.issue_is_branch  = ($urandom_range(99) < 20);
            bus.issue_pred_taken = 1'($urandom);
            bus.issue_alt_pc     = $urandom;
            bus.cdb_valid        = ($urandom_range(99) < 60);
            if (q.size() > 0 && $urandom_range(9) < 8)
                bus.cdb_tag = q[$urandom_range(q.size() - 1)].tag;
            else
                bus.cdb_tag = 4'($urandom);
            bus.cdb_value  = $urandom;
            bus.cdb_taken  = ($urandom_range(99) < 70);
            bus.query_tag1 = 4'($urandom);
            bus.query_tag2 = (q.size() > 0) ? q[0].tag : 4'($urandom);
            tick();
        end
        rst = 1'b0; rdy = 1'b1;
        idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the Tomasulo core; the writer side of the register file's commit interface.
- Receives dispatched instructions from the decoder/RS stage and captures results broadcast on the CDB.
- Retires entries strictly in program order, driving commit_valid/commit_index/commit_value/commit_tag to the register file.
- Detects branch mispredictions at the head, flushes, and raises jump_wrong with a redirect PC.

Parameters:
- ROB_SIZE, 16, number of entries; power of two.
- TAG_W, 4, log2(ROB_SIZE); width of the ROB tags used for renaming.
- REG_W, 5, architectural register index width.
- DATA_W, 32, data and PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when 0 no state or output changes.
- issue_valid  in  1  dispatch request this cycle.
- issue_rd  in  REG_W  destination register.
- issue_is_branch  in  1  entry is a conditional branch (no destination write).
- issue_pred_taken  in  1  predicted direction.
- issue_alt_pc  in  DATA_W  PC to fetch from if the prediction is wrong.
- issue_tag  out  TAG_W  combinational; equals tail, the tag given to this dispatch.
- rob_full  out  1  combinational; count==ROB_SIZE.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  producing entry.
- cdb_value  in  DATA_W  result value.
- cdb_taken  in  1  actual branch outcome; ignored for non-branch entries.
- query_tag1, query_tag2  in  TAG_W  operand lookups from the RS.
- query_ready1, query_ready2  out  1  combinational; value available.
- query_value1, query_value2  out  DATA_W  combinational operand value.
- commit_valid  out  1  registered pulse; register write this cycle.
- commit_index  out  REG_W  register written.
- commit_value  out  DATA_W  value written.
- commit_tag  out  TAG_W  tag of the retired entry; the register file clears the rename only if it matches.
- jump_wrong  out  1  registered one-cycle flush pulse.
- redirect_pc  out  DATA_W  valid while jump_wrong=1.

Behaviour:
- Storage:
  - Circular buffer with head, tail and count (TAG_W+1 bits).
  - Per-entry fields: busy, ready, has_dest, is_branch, pred_taken, taken, rd, value, alt_pc.
- Reset (rst=1 at a clock edge, overrides rdy):
  - head=tail=count=0; all busy and ready bits cleared.
  - commit_valid=0, commit_index=0, commit_value=0, commit_tag=0, jump_wrong=0, redirect_pc=0.
  - Reset mid-operation discards all entries with no commit and no jump_wrong.
- rdy=0: every register, including commit_valid and jump_wrong, holds its value. The register file is gated by the same rdy, so a held pulse is not applied twice.
- Issue: accepted when issue_valid && !rob_full && !jump_wrong.
  - Entry[tail] gets busy=1, ready=0, rd, is_branch, pred_taken, alt_pc.
  - has_dest = !issue_is_branch && issue_rd!=0.
  - tail wraps modulo ROB_SIZE.
  - issue_valid while full: no state change; the upstream stage must hold the request.
- CDB capture: if cdb_valid and entry[cdb_tag].busy, set ready=1, value=cdb_value, taken=cdb_taken. A CDB write to a non-busy entry is ignored.
- Commit: one entry per cycle, evaluated only from registered state. An entry whose ready is set by the CDB in cycle N can commit at cycle N+1 at the earliest.
  - If count>0 and entry[head].ready:
    - Non-branch entry: pop it. Next cycle commit_valid=has_dest, commit_index=rd, commit_value=value, commit_tag=head.
    - Branch with taken==pred_taken: pop it; commit_valid=0.
    - Branch with taken!=pred_taken: next cycle jump_wrong=1 and redirect_pc=alt_pc. All entries are flushed: busy cleared, head=tail=0, count=0. Any issue in the same cycle is dropped and a CDB write in the same cycle is discarded. commit_valid=0.
  - Otherwise commit_valid=0. jump_wrong stays high exactly one cycle.
- Count rules:
  - Issue and pop in the same cycle: count unchanged.
  - Issue into the slot being popped (full buffer, head==tail) is not accepted, because rob_full is computed before the pop.
- Query ports:
  - ready = entry.ready || (cdb_valid && cdb_tag==query_tag && entry busy).
  - value is taken from the CDB on a bypass hit, otherwise from the entry.
  - Non-busy tag: ready=0, value=0.

Test Plan:
- Reset, then issue rd=5 (tag 0); CDB tag0 value 0x1234 at cycle 3 -> one cycle later commit_valid=1, commit_index=5, commit_value=0x1234, commit_tag=0, count back to 0.
- Issue 16 entries -> rob_full=1 and a 17th issue is ignored; CDB all 16 in reverse order -> commits in tag order 0..15, one per cycle; tail wraps to 0.
- Issue rd=0 and a branch (pred=1, actual=1) -> both retire with commit_valid=0 and jump_wrong=0.
- Branch tag 2 (pred=0, alt_pc=0x100) followed by 3 younger entries; CDB taken=1 -> jump_wrong=1 for exactly one cycle, redirect_pc=0x100, count=0, younger entries never commit, and an issue in the flush cycle is dropped.
- query_tag1=3 with cdb_valid, cdb_tag=3, value 0xAB in the same cycle -> query_ready1=1, query_value1=0xAB combinationally.
- Hold rdy=0 for 3 cycles with a ready head entry -> no commit and outputs frozen; assert rst mid-stream -> all outputs 0 and count=0 the next cycle.
